wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_rr_pick.sv | 52 +++++
 rtl/wb_arbiter.sv | 72 +++++++
 tb/tb_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU definitions for the writeback arbiter: register-file widths,
// the hard-wired zero register, and conflict counter limits.
package wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

  // Writes to the zero register are architecturally discarded.
  function automatic logic writes_reg(input logic [REG_IDX_W-1:0] rd);
    return rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Two-input grant picker. Round-robin with a favour pointer when
// WB_RR_ARB_EN is defined, otherwise fixed priority to requester 1 (load).
module wb_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o
);

`ifdef WB_RR_ARB_EN
  req_id_e favour_q, favour_d;

  always_ff @(posedge clk) begin
    if (reset) favour_q <= REQ_EXEC;
    else       favour_q <= favour_d;
  end

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (!reset) begin
      if (valid0_i && valid1_i) begin
        grant0_o = (favour_q == REQ_EXEC);
        grant1_o = (favour_q == REQ_LOAD);
      end else begin
        grant0_o = valid0_i;
        grant1_o = valid1_i;
      end
    end
  end

  // The pointer moves only on an actual grant, towards the other requester.
  always_comb begin
    favour_d = favour_q;
    if (grant0_o)      favour_d = REQ_LOAD;
    else if (grant1_o) favour_d = REQ_EXEC;
  end
`else
  logic unusedClk;
  assign unusedClk = clk;

  always_comb begin
    grant1_o = valid1_i && !reset;
    grant0_o = valid0_i && !valid1_i && !reset;
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter for execute and load requesters.
// Arbitration policy selected by macro WB_RR_ARB_EN (round-robin when defined).
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [REG_IDX_W-1:0] req0_rd,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [REG_IDX_W-1:0] req1_rd,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [DATA_W-1:0]    rf_din,
  output logic                 rf_write,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic           write_q, write_d;
  wb_req_t        stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  wb_rr_pick u_pick (
    .clk      (clk),
    .reset    (reset),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant0_o (req0_ready),
    .grant1_o (req1_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      write_q <= write_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Zero-register requests are accepted but leave the staged write untouched.
  always_comb begin
    write_d = 1'b0;
    stage_d = stage_q;
    if (req0_valid && req0_ready && writes_reg(req0_rd)) begin
      write_d = 1'b1;
      stage_d = '{rd: req0_rd, data: req0_data};
    end else if (req1_valid && req1_ready && writes_reg(req1_rd)) begin
      write_d = 1'b1;
      stage_d = '{rd: req1_rd, data: req1_data};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid && req1_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Outputs are forced low for the whole reset pulse, including its first
  // cycle, so a write staged just before reset never reaches the register file.
  assign rf_write     = write_q && !reset;
  assign rf_rd        = reset ? '0 : stage_q.rd;
  assign rf_din       = reset ? '0 : stage_q.data;
  assign conflict_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a rule-level reference model.
// Honours WB_RR_ARB_EN to select the expected arbitration policy.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        v0, v1;
  logic [4:0]  rd0, rd1;
  logic [31:0] d0, d1;
  logic        req0_ready, req1_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic        rf_write;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int passed = 0;

  bit          mLast1;
  bit          mWrite;
  logic [4:0]  mRd;
  logic [31:0] mDin;
  int          mCnt;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (v0),
    .req0_rd      (rd0),
    .req0_data    (d0),
    .req0_ready   (req0_ready),
    .req1_valid   (v1),
    .req1_rd      (rd1),
    .req1_data    (d1),
    .req1_ready   (req1_ready),
    .rf_rd        (rf_rd),
    .rf_din       (rf_din),
    .rf_write     (rf_write),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rule: a lone requester wins; a conflict goes to load, or under
  // round-robin to whichever requester was not granted most recently.
  function automatic void expReady(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) return;
    if (v0 && v1) begin
`ifdef WB_RR_ARB_EN
      if (mLast1) g0 = 1'b1;
      else        g1 = 1'b1;
`else
      g1 = 1'b1;
`endif
    end else begin
      g0 = v0;
      g1 = v1;
    end
  endfunction

  function automatic logic [55:0] expOutputs();
    bit g0, g1;
    expReady(g0, g1);
    if (reset) return 56'b0;
    return {g0, g1, mWrite, mRd, mDin, mCnt[15:0]};
  endfunction

  function automatic logic [55:0] dutOutputs();
    return {req0_ready, req1_ready, rf_write, rf_rd, rf_din, conflict_cnt};
  endfunction

  task automatic modelEdge();
    bit g0, g1;
    expReady(g0, g1);
    if (reset) begin
      mWrite = 1'b0;
      mRd    = '0;
      mDin   = '0;
      mCnt   = 0;
      mLast1 = 1'b1;
      return;
    end
    mWrite = 1'b0;
    if (g0) begin
      mLast1 = 1'b0;
      if (rd0 != 5'd0) begin mWrite = 1'b1; mRd = rd0; mDin = d0; end
    end
    if (g1) begin
      mLast1 = 1'b1;
      if (rd1 != 5'd0) begin mWrite = 1'b1; mRd = rd1; mDin = d1; end
    end
    if (v0 && v1 && mCnt < 65535) mCnt++;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v0 = 1'b1; rd0 = 5'd3; d0 = 32'h1111_2222;
    v1 = 1'b1; rd1 = 5'd4; d1 = 32'h3333_4444;
    @(negedge clk);
    checks++;
    if (dutOutputs() !== 56'b0)
      $display("[TB] FAIL reset_outputs actual=%h required=%h", dutOutputs(), 56'b0);
    else passed++;
    tick();
    tick();
    v0 = 1'b0; v1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dutOutputs() !== 56'b0)
      $display("[TB] FAIL after_reset_idle actual=%h required=%h", dutOutputs(), 56'b0);
    else passed++;
  endtask

  task automatic test_single();
    v0 = 1'b1; rd0 = 5'd5; d0 = 32'hDEADBEEF;
    v1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("[TB] FAIL single_ready actual=%b required=%b", {req0_ready, req1_ready}, 2'b10);
    else passed++;
    tick();
    v0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_write, rf_rd, rf_din} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("[TB] FAIL single_write actual=%b/%0d/%h required=1/5/deadbeef", rf_write, rf_rd, rf_din);
    else passed++;
  endtask

  task automatic test_conflict();
    int grantSeq[$];
    int rdSeq[$];
    bit seen0, seen1;
    int firstG, secondG;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = 1'b1; rd0 = 5'd1; d0 = 32'hA0A0_0001;
    v1 = 1'b1; rd1 = 5'd2; d1 = 32'hB0B0_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready && req1_ready)
        $display("[TB] FAIL conflict_one_grant cycle=%0d actual=11 required=at most one", i);
      else passed++;
      if (rf_write) rdSeq.push_back(int'(rf_rd));
      seen0 = req0_ready;
      seen1 = req1_ready;
      if (seen0) grantSeq.push_back(0);
      if (seen1) grantSeq.push_back(1);
      tick();
      if (seen0) v0 = 1'b0;
      if (seen1) v1 = 1'b0;
    end
`ifdef WB_RR_ARB_EN
    firstG = 0; secondG = 1;
`else
    firstG = 1; secondG = 0;
`endif
    checks++;
    if (grantSeq.size() != 2 || grantSeq[0] != firstG || grantSeq[1] != secondG)
      $display("[TB] FAIL conflict_order actual=%p required='{%0d,%0d}", grantSeq, firstG, secondG);
    else passed++;
    checks++;
    if (rdSeq.size() != 2 || rdSeq[0] != firstG + 1 || rdSeq[1] != secondG + 1)
      $display("[TB] FAIL conflict_rd_seq actual=%p required='{%0d,%0d}", rdSeq, firstG + 1, secondG + 1);
    else passed++;
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'd1)
      $display("[TB] FAIL conflict_count actual=%0d required=1", conflict_cnt);
    else passed++;
  endtask

  task automatic test_zero_rd();
    logic [4:0] heldRd;
    heldRd = mRd;
    v0 = 1'b0;
    v1 = 1'b1; rd1 = 5'd0; d1 = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1)
      $display("[TB] FAIL zero_rd_ready actual=%b required=1", req1_ready);
    else passed++;
    tick();
    v1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_write, rf_rd} !== {1'b0, heldRd})
      $display("[TB] FAIL zero_rd_nowrite actual=%b/%0d required=0/%0d", rf_write, rf_rd, heldRd);
    else passed++;
  endtask

  task automatic test_reset_discard();
    v0 = 1'b1; rd0 = 5'd7; d0 = $urandom;
    v1 = 1'b0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1)
      $display("[TB] FAIL discard_accept actual=%b required=1", req0_ready);
    else passed++;
    tick();
    v0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dutOutputs() !== 56'b0)
      $display("[TB] FAIL discard_in_reset actual=%h required=%h", dutOutputs(), 56'b0);
    else passed++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_write, conflict_cnt} !== 17'b0)
      $display("[TB] FAIL discard_after_reset actual=%b/%0d required=0/0", rf_write, conflict_cnt);
    else passed++;
  endtask

  // Requesters hold valid/rd/data stable until granted, then pick new work.
  task automatic test_random();
    bit g0, g1;
    logic [55:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      exp = expOutputs();
      expReady(g0, g1);
      checks++;
      if (dutOutputs() !== exp)
        $display("[TB] FAIL random cycle=%0d actual=%h required=%h", i, dutOutputs(), exp);
      else passed++;
      tick();
      if (g0 || !v0) begin
        v0 = ($urandom % 3) != 0; rd0 = 5'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (g1 || !v1) begin
        v1 = ($urandom % 3) != 0; rd1 = 5'($urandom_range(0, 31)); d1 = $urandom;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_saturation();
    bit g0, g1;
    logic [55:0] exp;
    logic prevR0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = 1'b1; rd0 = 5'($urandom_range(1, 31)); d0 = $urandom;
    v1 = 1'b1; rd1 = 5'($urandom_range(1, 31)); d1 = $urandom;
    prevR0 = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      exp = expOutputs();
      expReady(g0, g1);
      checks++;
      if (dutOutputs() !== exp)
        $display("[TB] FAIL saturation cycle=%0d actual=%h required=%h", i, dutOutputs(), exp);
      else passed++;
`ifdef WB_RR_ARB_EN
      if (i > 0) begin
        checks++;
        if (req0_ready === prevR0)
          $display("[TB] FAIL rr_alternate cycle=%0d actual=%b required=%b", i, req0_ready, !prevR0);
        else passed++;
      end
`endif
      prevR0 = req0_ready;
      tick();
      if (g0) begin rd0 = 5'($urandom_range(1, 31)); d0 = $urandom; end
      if (g1) begin rd1 = 5'($urandom_range(1, 31)); d1 = $urandom; end
    end
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'hFFFF)
      $display("[TB] FAIL saturation_final actual=%h required=ffff", conflict_cnt);
    else passed++;
    v0 = 1'b0; v1 = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
    mLast1 = 1'b1; mWrite = 1'b0; mRd = '0; mDin = '0; mCnt = 0;
    test_reset();
    tick();
    test_single();
    test_conflict();
    test_zero_rd();
    test_reset_discard();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
